// File: rtl/adder_result_stage.sv
// Two-entry skid buffer for adder results with sticky carry/overflow flags
// and a saturating overflow counter; in_ready is registered.
module adder_result_stage #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_sum,
  input  logic         in_carry,
  input  logic         in_overflow,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic         out_carry,
  output logic         out_overflow,
  input  logic         clr_sticky,
  output logic         sticky_carry,
  output logic         sticky_overflow,
  output logic [15:0]  ovf_count
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t        state_q, state_d;
  logic          in_ready_q, out_valid_q;
  logic          accept, xfer;
  logic          load_main_in, load_skid_in, load_main_skid;

  logic [N-1:0]  main_sum_p0, skid_sum_p0;
  logic          main_carry_p0, skid_carry_p0;
  logic          main_ovf_p0, skid_ovf_p0;

  logic          sticky_carry_q, sticky_ovf_q;
  logic [15:0]   ovf_count_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    sat_inc = (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  assign accept = in_valid & in_ready_q;
  assign xfer   = out_valid_q & out_ready;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_skid_in   = 1'b0;
    load_main_skid = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d      = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && !xfer) begin
          state_d      = FULL;
          load_skid_in = 1'b1;
        end else if (accept && xfer) begin
          load_main_in = 1'b1;
        end else if (xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (xfer) begin
          state_d        = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Control stage: state, handshake flags, sticky flags and counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= EMPTY;
      in_ready_q     <= 1'b1;
      out_valid_q    <= 1'b0;
      sticky_carry_q <= 1'b0;
      sticky_ovf_q   <= 1'b0;
      ovf_count_q    <= 16'd0;
    end else begin
      state_q        <= state_d;
      in_ready_q     <= (state_d != FULL);
      out_valid_q    <= (state_d != EMPTY);
      // a setting accept wins over a simultaneous clear
      sticky_carry_q <= (sticky_carry_q & ~clr_sticky) | (accept & in_carry);
      sticky_ovf_q   <= (sticky_ovf_q & ~clr_sticky) | (accept & in_overflow);
      if (clr_sticky)
        ovf_count_q <= (accept && in_overflow) ? 16'd1 : 16'd0;
      else if (accept && in_overflow)
        ovf_count_q <= sat_inc(ovf_count_q);
    end
  end

  // Main register stage: oldest entry, cleared by reset so outputs read zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_sum_p0   <= '0;
      main_carry_p0 <= 1'b0;
      main_ovf_p0   <= 1'b0;
    end else if (load_main_in) begin
      main_sum_p0   <= in_sum;
      main_carry_p0 <= in_carry;
      main_ovf_p0   <= in_overflow;
    end else if (load_main_skid) begin
      main_sum_p0   <= skid_sum_p0;
      main_carry_p0 <= skid_carry_p0;
      main_ovf_p0   <= skid_ovf_p0;
    end
  end

  // Skid register stage: only read while FULL, so it needs no reset
  always_ff @(posedge clk) begin
    if (load_skid_in) begin
      skid_sum_p0   <= in_sum;
      skid_carry_p0 <= in_carry;
      skid_ovf_p0   <= in_overflow;
    end
  end

  assign in_ready        = in_ready_q;
  assign out_valid       = out_valid_q;
  assign out_sum         = main_sum_p0;
  assign out_carry       = main_carry_p0;
  assign out_overflow    = main_ovf_p0;
  assign sticky_carry    = sticky_carry_q;
  assign sticky_overflow = sticky_ovf_q;
  assign ovf_count       = ovf_count_q;

endmodule

// File: doc/adder_result_stage.md
ADDER_RESULT_STAGE -- requirements
Module: adder_result_stage

Interface
REQ-001 Parameter N, default 32, SHALL set the data width of the sum path and SHALL be at least 2.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 in_valid  input  1  SHALL indicate that an adder result is presented on in_sum/in_carry/in_overflow.
REQ-005 in_ready  output  1  SHALL indicate the stage can accept a result this cycle.
REQ-006 in_sum  input  N  SHALL be the adder sum S.
REQ-007 in_carry  input  1  SHALL be the adder carry-out.
REQ-008 in_overflow  input  1  SHALL be the adder signed-overflow flag.
REQ-009 out_valid  output  1  SHALL indicate that a buffered result is presented downstream.
REQ-010 out_ready  input  1  SHALL indicate the downstream consumer takes the presented result.
REQ-011 out_sum  output  N  SHALL be the buffered sum.
REQ-012 out_carry, out_overflow  output  1 each  SHALL be the buffered flags travelling with out_sum.
REQ-013 clr_sticky  input  1  SHALL be a synchronous clear request for sticky flags and the counter.
REQ-014 sticky_carry, sticky_overflow  output  1 each  SHALL be sticky event flags.
REQ-015 ovf_count  output  16  SHALL be the saturating count of accepted overflow results.

Function
REQ-016 Accept SHALL occur when in_valid and in_ready are both 1 at a rising edge; transfer SHALL occur when out_valid and out_ready are both 1.
REQ-017 Storage SHALL be a 2-entry skid buffer (main + skid registers), states EMPTY, ONE, FULL.
REQ-018 EMPTY: accept -> ONE; no accept -> EMPTY.
REQ-019 ONE: accept without transfer -> FULL; transfer without accept -> EMPTY; both or neither -> ONE.
REQ-020 FULL: transfer -> ONE (skid moves to main); no transfer -> FULL; no accept possible.
REQ-021 in_ready SHALL be a registered output equal to 1 in EMPTY and ONE, 0 in FULL; no combinational path from out_ready to in_ready.
REQ-022 out_valid SHALL be 1 exactly in ONE and FULL; out_* SHALL be the oldest stored entry.
REQ-023 Latency SHALL be one cycle: result accepted at edge k visible on out_* after edge k when the stage was EMPTY.
REQ-024 Throughput SHALL be one result per cycle with out_ready held 1; order SHALL be preserved; no result dropped or duplicated.
REQ-025 While out_valid=1 and out_ready=0, out_sum/out_carry/out_overflow SHALL remain stable.
REQ-026 Inputs with in_valid=0 SHALL not modify any state; in_sum contents are don't-care then.
REQ-027 sticky_carry SHALL set on an accept with in_carry=1; sticky_overflow on an accept with in_overflow=1.
REQ-028 clr_sticky=1 SHALL clear both sticky flags and ovf_count at the next edge; if a setting accept occurs in the same cycle, set SHALL win (flag=1).
REQ-029 ovf_count SHALL increment by 1 per accept with in_overflow=1 and saturate at 16'hFFFF.
REQ-030 clr_sticky and an overflow accept in the same cycle SHALL yield ovf_count=1.
REQ-031 Sticky flags and counter SHALL update on accept, independent of downstream transfer.

Reset
REQ-032 rst_n=0 SHALL immediately force state EMPTY, in_ready=1, out_valid=0, out_sum=0, out_carry=0, out_overflow=0, sticky flags=0, ovf_count=0.
REQ-033 Reset asserted mid-operation SHALL discard all buffered results; none SHALL appear after release.
REQ-034 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-035 N=32, out_ready=1, single accept in_sum=32'h0000_0005, carry=0, ovf=0 -> next cycle out_valid=1, out_sum=32'h0000_0005, then out_valid=0.
REQ-036 out_ready=0, accept 32'h11, 32'h22 back-to-back -> in_ready=0 after second; out_sum=32'h11 stable; raise out_ready -> 32'h11 then 32'h22 delivered in order, in_ready returns 1.
REQ-037 Accept in_sum=32'h0, carry=1, overflow=1 (0x80000000+0x80000000) -> sticky_carry=1, sticky_overflow=1, ovf_count=1; clr_sticky pulse alone -> all 0.
REQ-038 clr_sticky=1 same cycle as overflow accept with ovf_count=7 -> ovf_count=1, sticky_overflow=1.
REQ-039 Force ovf_count to 16'hFFFE via 65534 overflow accepts, then 3 more -> ovf_count=16'hFFFF.
REQ-040 Stage FULL, assert rst_n=0 mid-cycle -> out_valid=0, in_ready=1 immediately; after release no stale result emitted.
